// File: rtl/dmem_port.sv
// Memory-stage load/store responder: runs one word-wide req/ack bus transaction per access,
// stalls the pipeline while it is outstanding, and returns extended load data or an exception.
module dmem_port #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [7:0]  EXC_MISALIGN = 8'h04,
  parameter logic [7:0]  EXC_BUS      = 8'h05
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic        done_valid,
  output logic [31:0] load_data,
  output logic [7:0]  exc_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter only needs to reach TIMEOUT-1: the final BUSY cycle is detected, not counted.
  localparam int unsigned   CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          squash;
  logic          done_q;
  logic [7:0]    exc_q;
  logic [1:0]    lane;
  logic [1:0]    acc_size;
  logic          acc_signed;

  logic          start;
  logic          misaligned;
  logic [1:0]    size_n;
  logic [3:0]    be_next;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size_n     = size[1] ? 2'd2 : size;
    start      = ~rst & req_valid & (is_load | is_store) & ~flush
               & ((state == IDLE) | (state == RESP));
    misaligned = ((size_n == 2'd1) & addr[0]) | ((size_n == 2'd2) & (addr[1:0] != 2'b00));
    be_next    = 4'b1111;
    wdata_rep  = wdata;
    case (size_n)
      2'd0: begin
        be_next   = 4'b0001 << addr[1:0];
        wdata_rep = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_next   = 4'b0011 << {addr[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    // Aligned half accesses have lane[0] = 0, so one byte-granular shift serves every size.
    rd_shift = mem_rdata >> {lane, 3'b000};
    case (acc_size)
      2'd0:    rd_ext = {{24{acc_signed & rd_shift[7]}},  rd_shift[7:0]};
      2'd1:    rd_ext = {{16{acc_signed & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign stall      = start | (state == BUSY);
  assign done_valid = done_q & ~flush;
  assign exc_out    = done_valid ? exc_q : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      squash     <= 1'b0;
      done_q     <= 1'b0;
      exc_q      <= 8'h00;
      lane       <= 2'b00;
      acc_size   <= 2'b00;
      acc_signed <= 1'b0;
      load_data  <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
    end else begin
      // NOTE: state is written with non-blocking assignments so every branch sees pre-edge values.
      done_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (start && misaligned) begin
            state     <= RESP;
            done_q    <= 1'b1;
            exc_q     <= EXC_MISALIGN;
            load_data <= 32'h0;
          end else if (start) begin
            state      <= BUSY;
            tcnt       <= '0;
            squash     <= 1'b0;
            lane       <= addr[1:0];
            acc_size   <= size_n;
            acc_signed <= is_signed;
            mem_req    <= 1'b1;
            mem_we     <= is_store;
            mem_addr   <= {addr[31:2], 2'b00};
            mem_be     <= be_next;
            mem_wdata  <= wdata_rep;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // A flush here cannot cancel the bus cycle; it only hides the eventual response.
          if (mem_ack || tcnt == TLAST) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            done_q    <= ~(squash | flush);
            exc_q     <= mem_ack ? 8'h00 : EXC_BUS;
            load_data <= mem_ack ? rd_ext : 32'h0;
          end else begin
            tcnt <= tcnt + CW'(1);
            if (flush) squash <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: directed accesses against a transaction-level model checked every cycle,
// plus hand-computed literal expectations per access.
module tb_dmem_port;

  localparam int unsigned TO = 4;
  localparam logic [7:0]  EM = 8'h04;
  localparam logic [7:0]  EB = 8'h05;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0, is_signed = 1'b0;
  logic        flush = 1'b0, mem_ack = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
  logic        stall, done_valid, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [7:0]  exc_out;
  logic [3:0]  mem_be;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_port #(.TIMEOUT(TO), .EXC_MISALIGN(EM), .EXC_BUS(EB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load), .is_store(is_store),
    .size(size), .is_signed(is_signed), .addr(addr), .wdata(wdata), .flush(flush),
    .stall(stall), .done_valid(done_valid), .load_data(load_data), .exc_out(exc_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level, arithmetic) ----------------
  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd1) return a % 2 != 0;
    if (sz >= 2'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] extract_of(input logic [1:0] sz, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd / (32'd1 << (8 * (a % 4)))) % 256;
      if (sgn && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (rd / (32'd1 << (16 * ((a / 2) % 2)))) % 65536;
      if (sgn && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  bit          m_busy = 0, m_squash = 0, m_done = 0, m_sgn = 0, m_st = 0;
  int          m_cycles = 0;
  logic [7:0]  m_exc = 8'h00;
  logic [31:0] m_ld = 32'h0, m_addr = 32'h0, m_wd = 32'h0;
  logic [1:0]  m_size = 2'd0;

  function automatic bit start_now();
    return !rst && req_valid && (is_load || is_store) && !flush && !m_busy;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_cycles <= 0; m_squash <= 0; m_done <= 0; m_exc <= 8'h00; m_ld <= 32'h0;
    end else begin
      m_done <= 0;
      if (m_busy) begin
        if (mem_ack || m_cycles + 1 == int'(TO)) begin
          m_busy <= 0;
          m_done <= !(m_squash || flush);
          m_exc  <= mem_ack ? 8'h00 : EB;
          m_ld   <= mem_ack ? extract_of(m_size, m_sgn, m_addr, mem_rdata) : 32'h0;
        end else begin
          m_cycles <= m_cycles + 1;
          if (flush) m_squash <= 1;
        end
      end else if (start_now()) begin
        if (is_mis(size, addr)) begin
          m_done <= 1; m_exc <= EM; m_ld <= 32'h0;
        end else begin
          m_busy <= 1; m_cycles <= 0; m_squash <= 0;
          m_addr <= addr; m_size <= size; m_sgn <= is_signed; m_st <= is_store; m_wd <= wdata;
        end
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge sees a settled cycle.
  always @(negedge clk) begin
    bit dv;
    dv = m_done && !flush;
    check("stall",      32'(stall),      32'(start_now() || m_busy));
    check("mem_req",    32'(mem_req),    32'(m_busy));
    check("done_valid", 32'(done_valid), 32'(dv));
    check("exc_out",    32'(exc_out),    dv ? 32'(m_exc) : 32'h0);
    check("load_data",  load_data,       m_ld);
    if (m_busy) begin
      check("mem_we",   32'(mem_we),     32'(m_st));
      check("mem_addr", mem_addr,        m_addr - (m_addr % 4));
      check("mem_be",   32'(mem_be),     32'(be_of(m_size, m_addr)));
      if (m_st) check("mem_wdata", mem_wdata, rep_of(m_size, m_wd));
    end
  end

  // ---------------- directed driver ----------------
  int          r_stall, r_req, r_done;
  logic [7:0]  r_exc;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata;
  logic        r_we;

  // Called just after a posedge; presents one request, acks on the ack_on-th mem_req cycle
  // (0 = never), pulses flush on cycle flush_on, and returns once the access has settled.
  task automatic run_access(input string tag, input bit ld, input bit st, input logic [1:0] sz,
                            input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_on, input int flush_on);
    int k;
    r_stall = 0; r_req = 0; r_done = 0; r_exc = 8'h00;
    r_be = 4'h0; r_addr = 32'h0; r_wdata = 32'h0; r_we = 1'b0;
    k = 0;
    forever begin
      req_valid = (k == 0);
      if (k == 0) begin
        is_load = ld; is_store = st; size = sz; is_signed = sgn; addr = a; wdata = wd;
      end
      flush   = (k == flush_on);
      mem_ack = 1'b0;
      mem_rdata = rd;
      if (mem_req) begin
        r_req++;
        if (r_req == 1) begin
          r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata; r_we = mem_we;
        end
        if (r_req == ack_on) mem_ack = 1'b1;
      end
      #1;
      if (stall) r_stall++;
      if (done_valid) begin r_done++; r_exc = exc_out; end
      if (k > 0 && !stall && !mem_req) break;
      if (k >= 30) begin
        n_tests++; n_fail++;
        $display("FAIL %s watchdog: got %0d cycles, expected completion", tag, k);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    flush = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset stall",     32'(stall),      32'h0);
    check("reset mem_req",   32'(mem_req),    32'h0);
    check("reset done",      32'(done_valid), 32'h0);
    check("reset load_data", load_data,       32'h0);

    run_access("wload", 1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, -1);
    check("wload stall cycles", 32'(r_stall), 32'd4);
    check("wload req cycles",   32'(r_req),   32'd3);
    check("wload be",           32'(r_be),    32'hF);
    check("wload addr",         r_addr,       32'h100);
    check("wload done",         32'(r_done),  32'd1);
    check("wload exc",          32'(r_exc),   32'h0);
    check("wload data",         load_data,    32'hDEAD_BEEF);

    run_access("sbload", 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h8011_2233, 1, -1);
    check("sbload be",   32'(r_be), 32'h8);
    check("sbload data", load_data, 32'hFFFF_FF80);
    run_access("ubload", 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h8011_2233, 1, -1);
    check("ubload data", load_data, 32'h0000_0080);
    run_access("shload", 1, 0, 2'd1, 1, 32'h102, 32'h0, 32'h80FF_1234, 2, -1);
    check("shload be",   32'(r_be), 32'hC);
    check("shload data", load_data, 32'hFFFF_80FF);

    run_access("hstore", 0, 1, 2'd1, 0, 32'h202, 32'h0000_ABCD, 32'h0, 1, -1);
    check("hstore we",    32'(r_we),   32'h1);
    check("hstore be",    32'(r_be),   32'hC);
    check("hstore wdata", r_wdata,     32'hABCD_ABCD);
    check("hstore addr",  r_addr,      32'h200);
    check("hstore done",  32'(r_done), 32'd1);

    run_access("bstore_ldst", 1, 1, 2'd0, 0, 32'h301, 32'h0000_005A, 32'h0, 2, -1);
    check("bstore we",    32'(r_we), 32'h1);
    check("bstore be",    32'(r_be), 32'h2);
    check("bstore wdata", r_wdata,   32'h5A5A_5A5A);

    run_access("miswd", 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 1, -1);
    check("miswd req",   32'(r_req),   32'd0);
    check("miswd stall", 32'(r_stall), 32'd1);
    check("miswd done",  32'(r_done),  32'd1);
    check("miswd exc",   32'(r_exc),   32'h04);
    run_access("mishf_size3", 0, 1, 2'd3, 0, 32'h102, 32'h0, 32'h0, 1, -1);
    check("mis size3 exc", 32'(r_exc), 32'h04);
    run_access("misflush", 1, 0, 2'd1, 0, 32'h103, 32'h0, 32'h0, 1, 1);
    check("misflush done", 32'(r_done), 32'd0);

    run_access("tmo", 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h1111_1111, 0, -1);
    check("tmo req cycles", 32'(r_req),   32'd4);
    check("tmo stall",      32'(r_stall), 32'd5);
    check("tmo exc",        32'(r_exc),   32'h05);
    check("tmo data",       load_data,    32'h0);
    run_access("lastack", 1, 0, 2'd2, 0, 32'h304, 32'h0, 32'h1234_5678, 4, -1);
    check("lastack req cycles", 32'(r_req), 32'd4);
    check("lastack exc",        32'(r_exc), 32'h0);
    check("lastack done",       32'(r_done), 32'd1);
    check("lastack data",       load_data,  32'h1234_5678);

    run_access("flushbusy", 1, 0, 2'd2, 0, 32'h400, 32'h0, 32'hCAFE_F00D, 3, 2);
    check("flushbusy req cycles", 32'(r_req),  32'd3);
    check("flushbusy done",       32'(r_done), 32'd0);

    // Reset in the middle of a bus transaction.
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; size = 2'd2; addr = 32'h500;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstbusy req before", 32'(mem_req), 32'h1);
    rst = 1'b1; #1;
    check("rstbusy req",   32'(mem_req), 32'h0);
    check("rstbusy stall", 32'(stall),   32'h0);
    @(posedge clk); #1 rst = 1'b0;
    run_access("afterrst", 1, 0, 2'd2, 0, 32'h504, 32'h0, 32'h0BAD_F00D, 2, -1);
    check("afterrst done", 32'(r_done), 32'd1);
    check("afterrst data", load_data,   32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
